fetch_unit: RTL

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_pkg.sv | 25 ++
 rtl/fetch_fifo.sv | 81 ++++++++
 rtl/fetch_unit.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// fetch_pkg: constants and types shared by the fetch unit and its buffer.
package fetch_pkg;

  // Canonical RISC-V NOP (addi x0, x0, 0), shown on if_instr when nothing is buffered.
  localparam logic [31:0] NOP_INSTR = 32'h00000013;

  // Default number of instruction buffer entries (must be a power of two, >= 2).
  localparam int DEFAULT_DEPTH = 4;

  // Each buffer entry carries {pc, instr}.
  localparam int FIFO_WIDTH = 64;

  // Fetch sequencing states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_e;

  // True when an address is word aligned.
  function automatic logic is_word_aligned(input logic [31:0] addr);
    return (addr[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: instruction buffer holding {pc, instr} entries.
// Synchronous reset and flush; pointers wrap naturally because DEPTH is a
// power of two. Push into a full buffer and pop from an empty buffer are
// ignored so the occupancy count can never run out of range.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int WIDTH = FIFO_WIDTH
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head_data,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] DEPTH_CNT = (PW + 1)'(DEPTH);

  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PW:0]      count_q, count_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic             do_push;
  logic             do_pop;

  // Compute next pointers, occupancy and storage; flush wins over push/pop.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    mem_d    = mem_q;
    do_push  = push && (count_q != DEPTH_CNT);
    do_pop   = pop && (count_q != '0);
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: entries are only visible once counted.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign head_data = mem_q[rd_ptr_q];
  assign count     = count_q;

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch front end.
// Issues one-cycle-latency requests to instruction memory under a credit
// rule (buffered + in-flight < DEPTH), buffers responses with their pc, and
// hands the head to decode with a valid/ready handshake. A taken-branch
// redirect flushes the buffer, cancels the in-flight response and restarts
// fetch at the target on the next cycle.
// Build option: define FETCH_MISALIGN_CHECK_EN to halt with a sticky
// misalign_err on a misaligned redirect target; otherwise the target's low
// two bits are dropped and misalign_err stays 0.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h00000000,
  parameter int          DEPTH    = DEFAULT_DEPTH
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic        misalign_err
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW:0] DEPTH_EXT = (CW + 1)'(DEPTH);

  fetch_state_e  state_q, state_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic          inflight_q, inflight_d;
  logic [31:0]   inflight_pc_q, inflight_pc_d;

  logic [CW-1:0] count;
  logic [63:0]   head_data;
  logic          head_valid;
  logic [CW:0]   credit_used;
  logic          req_issue;
  logic          misaligned;
  logic [31:0]   target_pc;
  logic          fifo_push;
  logic          fifo_pop;
  logic          fifo_flush;

`ifdef FETCH_MISALIGN_CHECK_EN
  logic          misalign_q, misalign_d;
`endif

  // Slots already committed: buffered entries plus the outstanding request.
  assign credit_used = {1'b0, count} + {{CW{1'b0}}, inflight_q};
  assign head_valid  = (count != '0);

`ifdef FETCH_MISALIGN_CHECK_EN
  assign misaligned = !is_word_aligned(redirect_pc);
  assign target_pc  = redirect_pc;
`else
  assign misaligned = 1'b0;
  assign target_pc  = redirect_pc & 32'hFFFF_FFFC;
`endif

  // Next-state logic: sequencing, request issue and redirect handling.
  always_comb begin
    state_d       = state_q;
    fetch_pc_d    = fetch_pc_q;
    inflight_d    = 1'b0;
    inflight_pc_d = inflight_pc_q;
    req_issue     = 1'b0;
    fifo_flush    = 1'b0;
`ifdef FETCH_MISALIGN_CHECK_EN
    misalign_d    = misalign_q;
`endif
    case (state_q)
      IDLE: begin
        state_d = RUN;
      end
      RUN: begin
        req_issue = (credit_used < DEPTH_EXT);
        if (req_issue) begin
          fetch_pc_d    = fetch_pc_q + 32'd4;
          inflight_d    = 1'b1;
          inflight_pc_d = fetch_pc_q;
        end
        if (redirect) begin
          fifo_flush = 1'b1;
          inflight_d = 1'b0;
          if (misaligned) begin
            state_d    = HALT;
            fetch_pc_d = fetch_pc_q;
`ifdef FETCH_MISALIGN_CHECK_EN
            misalign_d = 1'b1;
`endif
          end else begin
            fetch_pc_d = target_pc;
          end
        end
      end
      HALT: begin
        state_d = HALT;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Only an uncancelled response to our own request enters the buffer.
  assign fifo_push = imem_rvalid && inflight_q && !fifo_flush;
  assign fifo_pop  = if_valid && if_ready;

  // Control registers; reset restarts fetch from RESET_PC and drops in-flight work.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      fetch_pc_q    <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= RESET_PC;
    end else begin
      state_q       <= state_d;
      fetch_pc_q    <= fetch_pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
    end
  end

`ifdef FETCH_MISALIGN_CHECK_EN
  // Sticky misaligned-target flag, cleared only by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      misalign_q <= 1'b0;
    end else begin
      misalign_q <= misalign_d;
    end
  end

  assign misalign_err = misalign_q && !reset;
`else
  assign misalign_err = 1'b0;
`endif

  fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (FIFO_WIDTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .flush     (fifo_flush),
    .push      (fifo_push),
    .push_data ({inflight_pc_q, imem_rdata}),
    .pop       (fifo_pop),
    .head_data (head_data),
    .count     (count)
  );

  // Outputs are forced to their idle values while reset is held.
  assign imem_req  = req_issue && !reset;
  assign imem_addr = reset ? RESET_PC : fetch_pc_q;
  assign if_valid  = head_valid && !reset;
  assign if_instr  = if_valid ? head_data[31:0]  : NOP_INSTR;
  assign if_pc     = if_valid ? head_data[63:32] : RESET_PC;

endmodule
